// File: rtl/mm_pkg.sv
// Shared types and default sizing for the output memory writer and its beat sequencer.
package mm_pkg;

  localparam int unsigned DEF_DATA_WIDTH          = 8;
  localparam int unsigned DEF_N                   = 4;
  localparam int unsigned DEF_ACCUM_DATA_WIDTH    = 16;
  localparam int unsigned DEF_MEMORY_ADDRESS_BITS = 64;
  localparam int unsigned DEF_PARALLEL_SIZE       = 4;

  localparam int unsigned OUT_WIDTH     = 2 * DEF_DATA_WIDTH + DEF_ACCUM_DATA_WIDTH;
  localparam int unsigned BEATS_PER_ROW = DEF_N / DEF_PARALLEL_SIZE;

  typedef logic [OUT_WIDTH-1:0] result_elem_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RESULT = 2'd1,
    WRITE       = 2'd2
  } writer_state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_memory_writer_tile_beat_sequencer.sv
// Row/chunk walk over one tile: tracks the beat address, next beat position and the final beat.
module tile_beat_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned P  = 4,
  parameter int unsigned AW = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_load_base,
  input  logic [AW-1:0]                         i_base,
  input  logic [AW-1:0]                         i_stride,
  input  logic                                  i_clear,
  input  logic                                  i_advance,
  output logic [AW-1:0]                         o_beat_addr,
  output logic [mm_pkg::idx_width(N)-1:0]       o_row_nxt,
  output logic [mm_pkg::idx_width(N/P)-1:0]     o_chunk_nxt,
  output logic                                  o_last_c
);
  import mm_pkg::*;

  localparam int unsigned BPR     = N / P;
  localparam int unsigned ROW_W   = idx_width(N);
  localparam int unsigned CHUNK_W = idx_width(BPR);

  logic [ROW_W-1:0]   r_row;
  logic [CHUNK_W-1:0] r_chunk;
  logic [AW-1:0]      r_row_base;
  logic [AW-1:0]      r_stride;
  logic [AW-1:0]      r_beat_addr;
  logic               w_row_end;
  logic [AW-1:0]      w_row_base_nxt;

  always_comb begin
    w_row_end      = (r_chunk == CHUNK_W'(BPR - 1));
    w_row_base_nxt = r_row_base + r_stride;
    o_chunk_nxt    = w_row_end ? '0 : r_chunk + 1'b1;
    o_row_nxt      = w_row_end ? r_row + 1'b1 : r_row;
    o_last_c       = w_row_end && (r_row == ROW_W'(N - 1));
  end

  // The beat address is kept as a running sum so no multiplier sits on the address path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_chunk     <= '0;
      r_row_base  <= '0;
      r_stride    <= '0;
      r_beat_addr <= '0;
    end else begin
      if (i_load_base) begin
        r_row_base  <= i_base;
        r_stride    <= i_stride;
        r_beat_addr <= i_base;
      end
      if (i_clear) begin
        r_row   <= '0;
        r_chunk <= '0;
      end else if (i_advance) begin
        r_row   <= o_row_nxt;
        r_chunk <= o_chunk_nxt;
        if (w_row_end) begin
          r_row_base  <= w_row_base_nxt;
          r_beat_addr <= w_row_base_nxt;
        end else begin
          r_beat_addr <= r_beat_addr + AW'(P);
        end
      end
    end
  end

  assign o_beat_addr = r_beat_addr;

endmodule

// File: rtl/output_memory_writer.sv
// Captures one N x N result tile per C address and streams it row-major into memory in P-wide beats.
module output_memory_writer #(
  parameter int unsigned DATA_WIDTH                   = mm_pkg::DEF_DATA_WIDTH,
  parameter int unsigned N                            = mm_pkg::DEF_N,
  parameter int unsigned MULTIPLY_DATA_WIDTH          = 2 * DATA_WIDTH,
  parameter int unsigned ACCUM_DATA_WIDTH             = mm_pkg::DEF_ACCUM_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH                    = MULTIPLY_DATA_WIDTH + ACCUM_DATA_WIDTH,
  parameter int unsigned MEMORY_ADDRESS_BITS          = mm_pkg::DEF_MEMORY_ADDRESS_BITS,
  parameter int unsigned PARALLEL_DATA_STREAMING_SIZE = mm_pkg::DEF_PARALLEL_SIZE
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                address_valid,
  output logic                                                address_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                      address_input,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                      row_stride_input,
  input  logic                                                result_valid,
  output logic                                                result_ready,
  input  logic [N-1:0][N-1:0][OUT_WIDTH-1:0]                  result_data,
  output logic                                                memory_write_valid,
  input  logic                                                memory_write_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]                      memory_write_address,
  output logic [PARALLEL_DATA_STREAMING_SIZE-1:0][OUT_WIDTH-1:0] memory_write_data,
  output logic                                                tile_done
);
  import mm_pkg::*;

  localparam int unsigned P       = PARALLEL_DATA_STREAMING_SIZE;
  localparam int unsigned BPR     = N / P;
  localparam int unsigned ROW_W   = idx_width(N);
  localparam int unsigned CHUNK_W = idx_width(BPR);

  if ((P == 0) || ((N % P) != 0)) begin : g_bad_beat_size
    $error("output_memory_writer: N must be a non-zero multiple of PARALLEL_DATA_STREAMING_SIZE");
  end
  if ((MULTIPLY_DATA_WIDTH != 2 * DATA_WIDTH) ||
      (OUT_WIDTH != MULTIPLY_DATA_WIDTH + ACCUM_DATA_WIDTH)) begin : g_bad_widths
    $error("output_memory_writer: inconsistent result element widths");
  end

  // Same bits as result_data, viewed so a row splits directly into beat-sized chunks.
  typedef logic [N-1:0][BPR-1:0][P-1:0][OUT_WIDTH-1:0] tile_t;

  writer_state_t                 r_state;
  writer_state_t                 w_state_nxt;
  logic                          w_addr_hs;
  logic                          w_capture;
  logic                          w_advance;
  logic                          w_last;
  logic [ROW_W-1:0]              w_row_nxt;
  logic [CHUNK_W-1:0]            w_chunk_nxt;
  tile_t                         w_tile_in;
  tile_t                         r_tile;
  logic                          r_result_ready;
  logic                          r_wr_valid;
  logic                          r_tile_done;
  logic [P-1:0][OUT_WIDTH-1:0]   r_wr_data;

  assign w_tile_in = result_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_hs   = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        w_addr_hs = address_valid;
        if (address_valid) w_state_nxt = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        w_capture = result_valid;
        if (result_valid) w_state_nxt = WRITE;
      end
      WRITE: begin
        w_advance = memory_write_ready;
        if (memory_write_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat data is loaded one cycle ahead: straight from the input on capture, else from the held tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile         <= '0;
      r_result_ready <= 1'b0;
      r_wr_valid     <= 1'b0;
      r_tile_done    <= 1'b0;
      r_wr_data      <= '0;
    end else begin
      r_result_ready <= (w_state_nxt == WAIT_RESULT);
      r_wr_valid     <= (w_state_nxt == WRITE);
      r_tile_done    <= w_advance && w_last;
      if (w_capture) begin
        r_tile    <= w_tile_in;
        r_wr_data <= w_tile_in[0][0];
      end else if (w_advance && !w_last) begin
        r_wr_data <= r_tile[w_row_nxt][w_chunk_nxt];
      end
    end
  end

  tile_beat_sequencer #(
    .N  (N),
    .P  (P),
    .AW (MEMORY_ADDRESS_BITS)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .i_load_base (w_addr_hs),
    .i_base      (address_input),
    .i_stride    (row_stride_input),
    .i_clear     (w_capture),
    .i_advance   (w_advance),
    .o_beat_addr (memory_write_address),
    .o_row_nxt   (w_row_nxt),
    .o_chunk_nxt (w_chunk_nxt),
    .o_last_c    (w_last)
  );

  assign address_ready      = (r_state == IDLE);
  assign result_ready       = r_result_ready;
  assign memory_write_valid = r_wr_valid;
  assign memory_write_data  = r_wr_data;
  assign tile_done          = r_tile_done;

endmodule

// File: tb/tb_output_memory_writer.sv
// Scoreboard bench: instance A uses N=4,P=2; instance B uses N=4,P=4 for the wrap-around case.
module tb_output_memory_writer;
  import mm_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned EW = OUT_WIDTH;

  typedef logic [3:0][3:0][EW-1:0] tile_t;
  typedef struct {
    logic [AW-1:0]      addr;
    result_elem_t [3:0] data;
    bit                 last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  logic av_a, ar_a, rv_a, rr_a, mwv_a, mwr_a, td_a;
  logic [AW-1:0] ai_a, si_a, mwa_a;
  tile_t rd_a;
  logic [1:0][EW-1:0] mwd_a;

  logic av_b, ar_b, rv_b, rr_b, mwv_b, mwr_b, td_b;
  logic [AW-1:0] ai_b, si_b, mwa_b;
  tile_t rd_b;
  logic [3:0][EW-1:0] mwd_b;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t q_a[$];
  beat_t q_b[$];
  int beats_a = 0, beats_b = 0, dones_a = 0, dones_b = 0;
  bit exp_done_a = 0, exp_done_b = 0;
  bit stall_a = 0;
  bit toggle_mode = 0;
  logic [AW-1:0] stall_addr;
  logic [1:0][EW-1:0] stall_data;

  always #5 clk = ~clk;

  output_memory_writer #(.N(4), .PARALLEL_DATA_STREAMING_SIZE(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .address_valid(av_a), .address_ready(ar_a),
    .address_input(ai_a), .row_stride_input(si_a),
    .result_valid(rv_a), .result_ready(rr_a), .result_data(rd_a),
    .memory_write_valid(mwv_a), .memory_write_ready(mwr_a),
    .memory_write_address(mwa_a), .memory_write_data(mwd_a),
    .tile_done(td_a)
  );

  output_memory_writer #(.N(4), .PARALLEL_DATA_STREAMING_SIZE(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .address_valid(av_b), .address_ready(ar_b),
    .address_input(ai_b), .row_stride_input(si_b),
    .result_valid(rv_b), .result_ready(rr_b), .result_data(rd_b),
    .memory_write_valid(mwv_b), .memory_write_ready(mwr_b),
    .memory_write_address(mwa_b), .memory_write_data(mwd_b),
    .tile_done(td_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic tile_t make_tile(input int mul_r, input int off, input bit rnd);
    tile_t t;
    logic [1:0] ri, ci;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ri = 2'(r);
        ci = 2'(c);
        t[ri][ci] = rnd ? EW'($urandom) : EW'(mul_r * r + c + off);
      end
    return t;
  endfunction

  // Reference beats derived directly from base + row*stride + chunk*P, row-major.
  task automatic push_tile(input bit sel, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input tile_t t);
    int p;
    beat_t b;
    logic [1:0] ri, ci, ki;
    p = sel ? 4 : 2;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4 / p; c++) begin
        b.addr = base + AW'(r) * stride + AW'(c * p);
        b.data = '0;
        for (int k = 0; k < p; k++) begin
          ri = 2'(r);
          ci = 2'(c * p + k);
          ki = 2'(k);
          b.data[ki] = t[ri][ci];
        end
        b.last = (r == 3) && (c == 4 / p - 1);
        if (sel) q_b.push_back(b);
        else     q_a.push_back(b);
      end
  endtask

  task automatic send_addr(input bit sel, input logic [AW-1:0] base, input logic [AW-1:0] stride);
    bit ok = 0;
    if (sel) begin av_b = 1; ai_b = base; si_b = stride; end
    else     begin av_a = 1; ai_a = base; si_a = stride; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? ar_b : ar_a;
      @(posedge clk); #1;
    end
    if (sel) av_b = 0; else av_a = 0;
    check("addr_accepted", 128'(ok), 128'(1));
  endtask

  task automatic send_result(input bit sel, input tile_t t);
    bit ok = 0;
    if (sel) begin rv_b = 1; rd_b = t; end
    else     begin rv_a = 1; rd_a = t; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? rr_b : rr_a;
      @(posedge clk); #1;
    end
    if (sel) rv_b = 0; else rv_a = 0;
    check("result_accepted", 128'(ok), 128'(1));
  endtask

  task automatic wait_done(input bit sel, output int cycles);
    bit seen = 0;
    cycles = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      cycles++;
      seen = sel ? td_b : td_a;
    end
    check("tile_done_seen", 128'(seen), 128'(1));
  endtask

  initial begin
    mwr_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      mwr_a = toggle_mode ? ~mwr_a : 1'b1;
    end
  end

  // Monitor A: scoreboard pops, stall stability and tile_done timing.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stall_a    = 0;
      exp_done_a = 0;
    end else begin
      check("tile_done_a", 128'(td_a), 128'(exp_done_a));
      if (td_a) dones_a++;
      exp_done_a = 0;
      if (stall_a) begin
        check("stall_valid_a", 128'(mwv_a), 128'(1));
        check("stall_addr_a", 128'(mwa_a), 128'(stall_addr));
        check("stall_data_a", 128'(mwd_a), 128'(stall_data));
      end
      stall_a = mwv_a && !mwr_a;
      if (stall_a) begin
        stall_addr = mwa_a;
        stall_data = mwd_a;
      end
      if (mwv_a && mwr_a) begin
        beats_a++;
        check("beat_a_queued", 128'(q_a.size() != 0), 128'(1));
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          check("beat_addr_a", 128'(mwa_a), 128'(e.addr));
          check("beat_data_a", 128'(mwd_a), 128'(e.data));
          exp_done_a = e.last;
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      exp_done_b = 0;
    end else begin
      check("tile_done_b", 128'(td_b), 128'(exp_done_b));
      if (td_b) dones_b++;
      exp_done_b = 0;
      if (mwv_b && mwr_b) begin
        beats_b++;
        check("beat_b_queued", 128'(q_b.size() != 0), 128'(1));
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          check("beat_addr_b", 128'(mwa_b), 128'(e.addr));
          check("beat_data_b", 128'(mwd_b), 128'(e.data));
          exp_done_b = e.last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t t;
    int cyc;
    int b0;
    av_a = 0; rv_a = 0; ai_a = '0; si_a = '0; rd_a = '0;
    av_b = 0; rv_b = 0; ai_b = '0; si_b = '0; rd_b = '0; mwr_b = 1'b1;
    reset = 0;
    #1 reset = 1;
    #1;
    check("rst_addr_ready", 128'(ar_a), 128'(1));
    check("rst_result_ready", 128'(rr_a), 128'(0));
    check("rst_wr_valid", 128'(mwv_a), 128'(0));
    check("rst_tile_done", 128'(td_a), 128'(0));
    check("rst_wr_addr", 128'(mwa_a), 128'(0));
    check("rst_wr_data", 128'(mwd_a), 128'(0));
    check("rst_wr_valid_b", 128'(mwv_b), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Basic tile, ready always high: 8 beats back to back, done one cycle after the last.
    t = make_tile(10, 0, 0);
    send_addr(0, 64'd100, 64'd16);
    push_tile(0, 64'd100, 64'd16, t);
    send_result(0, t);
    wait_done(0, cyc);
    check("throughput_cycles", 128'(cyc), 128'(8));

    // Same tile with ready toggling; monitor checks held outputs on stalls.
    toggle_mode = 1;
    send_addr(0, 64'd100, 64'd16);
    push_tile(0, 64'd100, 64'd16, t);
    send_result(0, t);
    wait_done(0, cyc);
    toggle_mode = 0;
    @(posedge clk); #1;

    // Result offered before any address.
    t = make_tile(7, 500, 0);
    rv_a = 1; rd_a = t;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_before_addr", 128'(rr_a), 128'(0));
      @(posedge clk); #1;
    end
    push_tile(0, 64'd300, 64'd8, t);
    send_addr(0, 64'd300, 64'd8);
    @(negedge clk);
    check("rr_in_wait", 128'(rr_a), 128'(1));
    check("valid_before_capture", 128'(mwv_a), 128'(0));
    @(posedge clk); #1;
    rv_a = 0;
    @(negedge clk);
    check("first_beat_latency", 128'(mwv_a), 128'(1));
    wait_done(0, cyc);

    // Reset after three beats: everything dropped, no tile_done.
    t = make_tile(0, 0, 1);
    send_addr(0, 64'd200, 64'd8);
    push_tile(0, 64'd200, 64'd8, t);
    b0 = beats_a;
    send_result(0, t);
    for (int i = 0; i < 50 && beats_a < b0 + 3; i++) begin
      @(posedge clk); #1;
    end
    check("beats_before_reset", 128'(beats_a - b0), 128'(3));
    reset = 1;
    #1;
    check("mid_rst_addr_ready", 128'(ar_a), 128'(1));
    check("mid_rst_result_ready", 128'(rr_a), 128'(0));
    check("mid_rst_wr_valid", 128'(mwv_a), 128'(0));
    check("mid_rst_tile_done", 128'(td_a), 128'(0));
    check("mid_rst_wr_addr", 128'(mwa_a), 128'(0));
    check("mid_rst_wr_data", 128'(mwd_a), 128'(0));
    q_a.delete();
    @(posedge clk); #1;
    reset = 0;
    t = make_tile(3, 40, 0);
    b0 = beats_a;
    send_addr(0, 64'd0, 64'd4);
    push_tile(0, 64'd0, 64'd4, t);
    send_result(0, t);
    wait_done(0, cyc);
    check("beats_after_reset", 128'(beats_a - b0), 128'(8));

    // Back-to-back tiles: second address offered in the tile_done cycle.
    t = make_tile(0, 0, 1);
    send_addr(0, 64'd1000, 64'd20);
    push_tile(0, 64'd1000, 64'd20, t);
    send_result(0, t);
    wait_done(0, cyc);
    check("b2b_addr_ready", 128'(ar_a), 128'(1));
    t = make_tile(0, 0, 1);
    send_addr(0, 64'd5000, 64'd32);
    push_tile(0, 64'd5000, 64'd32, t);
    send_result(0, t);
    wait_done(0, cyc);

    // P == N with address wrap-around at the top of the address space.
    t = make_tile(100, 7, 0);
    send_addr(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4);
    push_tile(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4, t);
    send_result(1, t);
    wait_done(1, cyc);
    check("p_eq_n_cycles", 128'(cyc), 128'(4 * BEATS_PER_ROW));

    repeat (3) @(posedge clk);
    #1;
    check("q_a_empty", 128'(q_a.size()), 128'(0));
    check("q_b_empty", 128'(q_b.size()), 128'(0));
    check("dones_a", 128'(dones_a), 128'(6));
    check("dones_b", 128'(dones_b), 128'(1));
    check("beats_b", 128'(beats_b), 128'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
